// File: rtl/timer_run_ctrl_pkg.sv
// Shared types and constants for the AGC timer run/stop/restart controller.
// Timepulses run T01..T12; one full ring is one memory cycle time (MCT).
package timer_run_ctrl_pkg;

  localparam int T_IDX_W = 4;

  typedef logic [T_IDX_W-1:0] tp_t;

  localparam tp_t T_FIRST = 4'd1;
  localparam tp_t T_LAST  = 4'd12;

  typedef enum logic [2:0] {
    GOJ,
    RUN,
    STOP_PEND,
    STOPPED,
    STEP
  } state_e;

  function automatic tp_t tp_next(input tp_t t);
    return (t == T_LAST) ? T_FIRST : t + 4'd1;
  endfunction

endpackage

// File: rtl/timer_run_ctrl_if.sv
// Signal bundle between the timer/monitor side (master) and the run controller (slave).
interface timer_run_ctrl_if #(
  parameter int MCT_CNT_W = 16
);
  import timer_run_ctrl_pkg::*;

  logic                 PHASE_STB;
  logic                 MSTP;
  logic                 MSTRTP;
  logic                 STRT1;
  logic                 STRT2;
  logic                 ALGA;
  logic                 SBY;
  logic                 GOJ1;
  logic                 ADV_EN;
  tp_t                  T_IDX;
  logic                 MCT_END;
  logic                 GOJAM;
  logic                 GOJAM_n;
  logic                 STOP;
  logic                 STOP_n;
  logic                 STEP_ACT;
  logic [MCT_CNT_W-1:0] MCT_CNT;

  modport master (
    output PHASE_STB, MSTP, MSTRTP, STRT1, STRT2, ALGA, SBY, GOJ1,
    input  ADV_EN, T_IDX, MCT_END, GOJAM, GOJAM_n, STOP, STOP_n, STEP_ACT, MCT_CNT
  );

  modport slave (
    input  PHASE_STB, MSTP, MSTRTP, STRT1, STRT2, ALGA, SBY, GOJ1,
    output ADV_EN, T_IDX, MCT_END, GOJAM, GOJAM_n, STOP, STOP_n, STEP_ACT, MCT_CNT
  );

endinterface

// File: rtl/timer_run_ctrl_tp_cnt.sv
// Timepulse counter: advances on a qualified strobe, wraps T12->T01 and
// flags the end of each MCT with a registered one-cycle pulse.
module timer_run_ctrl_tp_cnt
  import timer_run_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic phase_stb,
  input  logic adv_en,
  output tp_t  t_idx,
  output logic mct_end,
  output logic wrap
);

  logic adv;

  assign adv  = phase_stb & adv_en;
  // Combinational so the controller can act on the same edge that wraps T_IDX.
  assign wrap = adv & (t_idx == T_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_idx   <= T_FIRST;
      mct_end <= 1'b0;
    end else begin
      mct_end <= wrap;
      if (adv) t_idx <= tp_next(t_idx);
    end
  end

endmodule

// File: rtl/timer_run_ctrl.sv
// AGC timer run controller: GOJAM restart sequencing, monitor stop and single-MCT step.
// Optional MCT counter enabled by defining TIMER_RUN_CTRL_MCT_CNT_EN.
module timer_run_ctrl
  import timer_run_ctrl_pkg::*;
#(
  parameter int GOJAM_MCTS = 2,
  parameter int MCT_CNT_W  = 16
) (
  input  logic             CLOCK,
  input  logic             SIM_RST,
  timer_run_ctrl_if.slave  bus
);

  localparam logic [3:0] GCNT_INIT = 4'(GOJAM_MCTS);

  state_e     state;
  logic [3:0] gcnt;
  logic       goj1_lat;
  logic       pend_goj;
  logic       mstrtp_q;
  logic       adv_en;
  logic       gojam;
  logic       stop;
  logic       step_act;

  tp_t        t_idx;
  logic       mct_end;
  logic       wrap;

  logic       lvl_src;
  logic       req;
  logic       mstrtp_rise;
  logic       goj_enter;

  timer_run_ctrl_tp_cnt u_tp_cnt (
    .clk       (CLOCK),
    .rst       (SIM_RST),
    .phase_stb (bus.PHASE_STB),
    .adv_en    (adv_en),
    .t_idx     (t_idx),
    .mct_end   (mct_end),
    .wrap      (wrap)
  );

  assign lvl_src     = bus.STRT1 | bus.STRT2 | bus.ALGA | bus.SBY;
  assign req         = lvl_src | bus.GOJ1 | goj1_lat;
  assign mstrtp_rise = bus.MSTRTP & ~mstrtp_q;
  // A pending restart only takes effect at an MCT boundary.
  assign goj_enter   = (state != GOJ) && (pend_goj || req) && wrap;

  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      state    <= GOJ;
      gcnt     <= GCNT_INIT;
      goj1_lat <= 1'b0;
      pend_goj <= 1'b0;
      mstrtp_q <= 1'b0;
      adv_en   <= 1'b1;
      gojam    <= 1'b1;
      stop     <= 1'b0;
      step_act <= 1'b0;
    end else begin
      mstrtp_q <= bus.MSTRTP;
      if (state == GOJ) begin
        gojam    <= 1'b1;
        adv_en   <= 1'b1;
        stop     <= 1'b0;
        step_act <= 1'b0;
        goj1_lat <= 1'b0;
        pend_goj <= 1'b0;
        if (lvl_src || bus.GOJ1) begin
          gcnt <= GCNT_INIT;
        end else if (wrap) begin
          if (gcnt == 4'd1) begin
            state <= RUN;
            gojam <= 1'b0;
          end else begin
            gcnt <= gcnt - 4'd1;
          end
        end
      end else if (pend_goj || req) begin
        // Restart outranks stop/step: keep the timer running to the wrap.
        adv_en   <= 1'b1;
        stop     <= 1'b0;
        step_act <= 1'b0;
        if (goj_enter) begin
          state    <= GOJ;
          gcnt     <= GCNT_INIT;
          gojam    <= 1'b1;
          goj1_lat <= 1'b0;
          pend_goj <= 1'b0;
        end else begin
          state    <= RUN;
          pend_goj <= 1'b1;
          goj1_lat <= goj1_lat | bus.GOJ1;
        end
      end else begin
        case (state)
          RUN: begin
            if (bus.MSTP) state <= STOP_PEND;
          end
          STOP_PEND: begin
            if (!bus.MSTP) begin
              state <= RUN;
            end else if (wrap) begin
              state  <= STOPPED;
              adv_en <= 1'b0;
              stop   <= 1'b1;
            end
          end
          STOPPED: begin
            if (!bus.MSTP) begin
              state  <= RUN;
              adv_en <= 1'b1;
              stop   <= 1'b0;
            end else if (mstrtp_rise) begin
              state    <= STEP;
              adv_en   <= 1'b1;
              stop     <= 1'b0;
              step_act <= 1'b1;
            end
          end
          STEP: begin
            if (wrap) begin
              step_act <= 1'b0;
              if (bus.MSTP) begin
                state  <= STOPPED;
                adv_en <= 1'b0;
                stop   <= 1'b1;
              end else begin
                state <= RUN;
              end
            end
          end
          default: state <= GOJ;
        endcase
      end
    end
  end

`ifdef TIMER_RUN_CTRL_MCT_CNT_EN
  logic [MCT_CNT_W-1:0] mct_cnt;

  // Counts only completed MCTs outside restart; no wraps occur while STOPPED.
  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      mct_cnt <= '0;
    end else if (state == GOJ || goj_enter) begin
      mct_cnt <= '0;
    end else if (wrap) begin
      mct_cnt <= mct_cnt + 1'b1;
    end
  end

  assign bus.MCT_CNT = mct_cnt;
`else
  assign bus.MCT_CNT = {MCT_CNT_W{1'b0}};
`endif

  assign bus.ADV_EN   = adv_en;
  assign bus.T_IDX    = t_idx;
  assign bus.MCT_END  = mct_end;
  assign bus.GOJAM    = gojam;
  assign bus.GOJAM_n  = ~gojam;
  assign bus.STOP     = stop;
  assign bus.STOP_n   = ~stop;
  assign bus.STEP_ACT = step_act;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Directed bench for timer_run_ctrl: restart, stop/step, cancel and counter behaviour.
// Expected timepulse/MCT_END values go through a scoreboard queue.
module tb_timer_run_ctrl;
  import timer_run_ctrl_pkg::*;

`ifdef TIMER_RUN_CTRL_MCT_CNT_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic CLOCK = 1'b0;
  logic SIM_RST = 1'b1;

  timer_run_ctrl_if #(.MCT_CNT_W(CW)) bus ();

  timer_run_ctrl #(.GOJAM_MCTS(2), .MCT_CNT_W(CW)) dut (
    .CLOCK   (CLOCK),
    .SIM_RST (SIM_RST),
    .bus     (bus)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_t    = 1;
  int   m_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    chk(e.tag, obs, e.val);
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef TIMER_RUN_CTRL_MCT_CNT_EN
    return 32'(m_cnt % (1 << CW));
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // One timepulse slot: strobe for a cycle, then three idle cycles.
  task automatic stb(input bit adv);
    bit w;
    w = adv && (m_t == 12);
    if (adv) m_t = (m_t == 12) ? 1 : m_t + 1;
    if (w) m_cnt++;
    push("t_idx", m_t);
    push("mct_end", {31'd0, w});
    bus.PHASE_STB = 1'b1;
    tick();
    bus.PHASE_STB = 1'b0;
    pop_chk(bus.T_IDX);
    pop_chk(bus.MCT_END);
    tick();
    if (w) chk("mct_end_one_cycle", bus.MCT_END, 0);
    tick();
    tick();
  endtask

  // Remaining GOJ period: GOJAM must hold until the last of n MCTs wraps.
  task automatic goj_run(input int n);
    for (int k = 1; k <= n * 12; k++) begin
      stb(1'b1);
      chk("gojam_hold", bus.GOJAM, (k == n * 12) ? 0 : 1);
    end
    chk("gojam_n_after_goj", bus.GOJAM_n, 1);
    m_cnt = 0;
  endtask

  initial begin
    bus.PHASE_STB = 1'b0;
    bus.MSTP      = 1'b0;
    bus.MSTRTP    = 1'b0;
    bus.STRT1     = 1'b0;
    bus.STRT2     = 1'b0;
    bus.ALGA      = 1'b0;
    bus.SBY       = 1'b0;
    bus.GOJ1      = 1'b0;

    // Reset state
    tick(); tick(); tick();
    SIM_RST = 1'b0;
    chk("rst_t_idx", bus.T_IDX, 1);
    chk("rst_adv_en", bus.ADV_EN, 1);
    chk("rst_gojam", bus.GOJAM, 1);
    chk("rst_gojam_n", bus.GOJAM_n, 0);
    chk("rst_stop", bus.STOP, 0);
    chk("rst_stop_n", bus.STOP_n, 1);
    chk("rst_step_act", bus.STEP_ACT, 0);
    chk("rst_mct_end", bus.MCT_END, 0);
    chk("rst_mct_cnt", bus.MCT_CNT, exp_cnt());

    // Power-on restart lasts exactly 2 MCTs
    goj_run(2);

    // Monitor stop requested at T05, takes effect at the wrap
    for (int i = 0; i < 4; i++) stb(1'b1);
    bus.MSTP = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      stb(1'b1);
      chk("stop_pend_adv", bus.ADV_EN, 1);
    end
    stb(1'b1);
    chk("stopped_adv", bus.ADV_EN, 0);
    chk("stopped_stop", bus.STOP, 1);
    chk("stopped_stop_n", bus.STOP_n, 0);
    stb(1'b0);
    chk("stopped_hold_stop", bus.STOP, 1);
    chk("stopped_cnt", bus.MCT_CNT, exp_cnt());

    // Single step: exactly 12 strobes, extra MSTRTP edge ignored
    bus.MSTRTP = 1'b1;
    tick();
    bus.MSTRTP = 1'b0;
    chk("step_act", bus.STEP_ACT, 1);
    chk("step_adv", bus.ADV_EN, 1);
    chk("step_stop", bus.STOP, 0);
    for (int i = 0; i < 6; i++) stb(1'b1);
    bus.MSTRTP = 1'b1;
    tick();
    bus.MSTRTP = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) stb(1'b1);
    chk("step_done_act", bus.STEP_ACT, 0);
    chk("step_done_stop", bus.STOP, 1);
    chk("step_done_adv", bus.ADV_EN, 0);
    stb(1'b0);
    chk("step_no_requeue", bus.STEP_ACT, 0);
    chk("stopped_cnt_hold", bus.MCT_CNT, exp_cnt());
    bus.MSTP = 1'b0;
    tick();
    chk("resume_stop", bus.STOP, 0);
    chk("resume_adv", bus.ADV_EN, 1);

    // Stop cancelled before the wrap
    for (int i = 0; i < 2; i++) stb(1'b1);
    bus.MSTP = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stb(1'b1);
      chk("cancel_stop", bus.STOP, 0);
      chk("cancel_adv", bus.ADV_EN, 1);
    end
    bus.MSTP = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stb(1'b1);
      chk("cancel_stop2", bus.STOP, 0);
      chk("cancel_adv2", bus.ADV_EN, 1);
    end
    chk("run_cnt", bus.MCT_CNT, exp_cnt());

    // GOJ1 pulse at T04: GOJAM waits for the wrap
    for (int i = 0; i < 3; i++) stb(1'b1);
    bus.GOJ1 = 1'b1;
    tick();
    bus.GOJ1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stb(1'b1);
      chk("goj1_pend_gojam", bus.GOJAM, 0);
    end
    stb(1'b1);
    chk("goj1_gojam", bus.GOJAM, 1);
    chk("goj1_gojam_n", bus.GOJAM_n, 0);
    m_cnt = 0;
    chk("goj1_cnt_clr", bus.MCT_CNT, exp_cnt());
    goj_run(2);

    // SBY held for 5 MCTs inside GOJ, then 2 more MCTs
    bus.SBY = 1'b1;
    for (int i = 0; i < 11; i++) stb(1'b1);
    chk("sby_pend_gojam", bus.GOJAM, 0);
    stb(1'b1);
    chk("sby_gojam", bus.GOJAM, 1);
    for (int i = 0; i < 60; i++) begin
      stb(1'b1);
      chk("sby_hold", bus.GOJAM, 1);
    end
    bus.SBY = 1'b0;
    goj_run(2);

    // Restart while stopped
    bus.MSTP = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) stb(1'b1);
    chk("rs_stopped", bus.STOP, 1);
    bus.ALGA = 1'b1;
    tick();
    bus.ALGA = 1'b0;
    chk("rs_adv", bus.ADV_EN, 1);
    for (int i = 0; i < 11; i++) stb(1'b1);
    chk("rs_pend_gojam", bus.GOJAM, 0);
    stb(1'b1);
    m_cnt = 0;
    chk("rs_gojam", bus.GOJAM, 1);
    chk("rs_stop", bus.STOP, 0);
    chk("rs_stop_n", bus.STOP_n, 1);
    bus.MSTP = 1'b0;
    goj_run(2);

    // 17 MCTs in RUN
    for (int i = 0; i < 17 * 12; i++) stb(1'b1);
    chk("cnt_17", bus.MCT_CNT, exp_cnt());

    // Restart source on the stop wrap: GOJ wins
    bus.MSTP = 1'b1;
    tick();
    for (int i = 0; i < 11; i++) stb(1'b1);
    bus.STRT1 = 1'b1;
    stb(1'b1);
    bus.STRT1 = 1'b0;
    bus.MSTP  = 1'b0;
    m_cnt = 0;
    chk("sim_gojam", bus.GOJAM, 1);
    chk("sim_stop", bus.STOP, 0);
    chk("sim_adv", bus.ADV_EN, 1);
    goj_run(2);

    // Mid-MCT reset aborts at once
    for (int i = 0; i < 5; i++) stb(1'b1);
    SIM_RST = 1'b1;
    tick();
    SIM_RST = 1'b0;
    m_t = 1;
    m_cnt = 0;
    chk("mid_rst_t_idx", bus.T_IDX, 1);
    chk("mid_rst_gojam", bus.GOJAM, 1);
    chk("mid_rst_adv", bus.ADV_EN, 1);
    chk("mid_rst_cnt", bus.MCT_CNT, exp_cnt());
    goj_run(2);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_run_ctrl.md
Name: timer_run_ctrl

Overview:
- Sequencing controller for the AGC timer (clock divider, phase generator, P01–P05 ring).
- Tracks the current timepulse T01–T12 from the timer's advance strobe and gates timer advance.
- Arbitrates restart sources into a memory-cycle-aligned GOJAM, and implements monitor stop (MSTP) and single-MCT step (MSTRTP).
- Sits between the timer and the monitor/alarm logic, replacing the discrete GOJAM/STOP latch network with a behavioural FSM.

Parameters:
- GOJAM_MCTS, 2: number of full MCTs GOJAM stays asserted after the last restart source clears (1..15).
- MCT_CNT_W, 16: width of the optional MCT counter.

Ports:
- CLOCK  in  1  system clock, all state on its rising edge
- SIM_RST  in  1  synchronous reset, active-high
- PHASE_STB  in  1  one-cycle strobe from timer; one timepulse elapses when PHASE_STB & ADV_EN
- MSTP  in  1  monitor stop request, level
- MSTRTP  in  1  monitor step, level; rising edge detected internally
- STRT1, STRT2, ALGA, SBY  in  1 each  level restart sources
- GOJ1  in  1  one-cycle alarm restart pulse
- ADV_EN  out  1  permits timer advance
- T_IDX  out  4  current timepulse, 1..12
- MCT_END  out  1  one-cycle pulse, registered, cycle after T_IDX wraps 12->1
- GOJAM, GOJAM_n  out  1  restart, true/complement
- STOP, STOP_n  out  1  stopped indication, true/complement
- STEP_ACT  out  1  high while executing a single-step MCT
- MCT_CNT  out  MCT_CNT_W  MCTs completed (optional feature)

Behaviour:
- Clock, reset and state:
  - All state is registered. SIM_RST is sampled on the CLOCK edge.
  - Reset values: state=GOJ, gcnt=GOJAM_MCTS, T_IDX=1, ADV_EN=1, MCT_END=0, GOJAM=1, GOJAM_n=0, STOP=0, STOP_n=1, STEP_ACT=0, MCT_CNT=0. This gives a power-on restart.
- Timepulse counter:
  - On PHASE_STB & ADV_EN: T_IDX increments, and 12 wraps to 1.
  - The wrap sets MCT_END on the next cycle for exactly one cycle.
  - PHASE_STB while ADV_EN=0 is ignored, and T_IDX holds.
- Restart request:
  - req = STRT1|STRT2|ALGA|SBY|GOJ1, with GOJ1 captured into a sticky latch.
  - req has priority over every other state.
  - In RUN, STOP_PEND, STOPPED or STEP, req sets pend_goj. ADV_EN is forced to 1 so the current MCT completes.
  - On the wrap while pend_goj is set: state becomes GOJ, gcnt=GOJAM_MCTS, and the latch and pend_goj are cleared.
- FSM states: GOJ, RUN, STOP_PEND, STOPPED, STEP.
  - GOJ:
    - GOJAM=1, ADV_EN=1.
    - While any level source is high, gcnt reloads to GOJAM_MCTS.
    - Otherwise gcnt decrements on each wrap. On the wrap where gcnt=1, go to RUN, and GOJAM falls the cycle after that wrap.
    - A GOJ1 arriving in GOJ reloads gcnt.
  - RUN: MSTP=1 goes to STOP_PEND.
  - STOP_PEND:
    - If MSTP=0, return to RUN (cancel).
    - Else, on the wrap go to STOPPED: ADV_EN=0 in the cycle after the wrap strobe, and T_IDX=1.
  - STOPPED:
    - STOP=1, ADV_EN=0.
    - If MSTP=0, go to RUN.
    - Else an MSTRTP rising edge goes to STEP.
  - STEP:
    - ADV_EN=1, STEP_ACT=1. Exactly 12 qualifying strobes are accepted (T01..T12).
    - On the wrap, go to STOPPED if MSTP=1, else RUN.
    - MSTRTP edges during STEP are ignored (not queued).
- Simultaneous events:
  - req on the same cycle as the stop wrap: GOJ wins.
  - MSTP falling on the same cycle as the STOP_PEND wrap: RUN, and ADV_EN stays 1.
- Outputs:
  - STOP=1 only in STOPPED.
  - GOJAM_n and STOP_n are always the exact complements of GOJAM and STOP.
- SIM_RST asserted mid-MCT aborts immediately to the reset values; there is no wait for the wrap.

Optional Feature:
- Macro: TIMER_RUN_CTRL_MCT_CNT_EN.
- Defined:
  - MCT_CNT increments on every wrap, modulo 2^MCT_CNT_W.
  - It clears on reset and on entry to GOJ.
  - It holds while STOPPED.
- Undefined: MCT_CNT is tied to 0 and the counter logic is absent.

Decomposition:
- Package timer_run_ctrl_pkg:
  - state enum {GOJ, RUN, STOP_PEND, STOPPED, STEP}
  - constants T_FIRST=1 and T_LAST=12
  - T_IDX width 4
- Sub-module timer_run_ctrl_tp_cnt: timepulse counter with advance qualify, 12->1 wrap, and registered MCT_END.
- The FSM, restart latch and MCT counter stay in the top module.

Test Plan:
- Reset:
  - Stimulus: SIM_RST for 3 cycles, then PHASE_STB every 4 cycles.
  - Response: GOJAM=1 for exactly 24 strobes (2 MCTs), falls the cycle after the 2nd MCT_END; T_IDX cycles 1..12.
- Stop and step:
  - Stimulus: in RUN with T_IDX=5, raise MSTP.
  - Response: advances continue to the wrap, then ADV_EN=0, STOP=1, T_IDX=1.
  - Stimulus: MSTRTP pulse.
  - Response: STEP_ACT=1, exactly 12 strobes accepted, back to STOPPED with T_IDX=1.
- Stop cancel: MSTP pulsed high at T_IDX=3 and dropped at T_IDX=7 -> STOP never asserts, ADV_EN never falls.
- Restart hold:
  - Stimulus: GOJ1 pulse at T_IDX=4.
  - Response: GOJAM rises the cycle after the next wrap, stays for 2 MCTs.
  - Stimulus: SBY held high 5 MCTs in GOJ.
  - Response: GOJAM held for 5 MCTs plus 2 after SBY falls.
- Restart while stopped: in STOPPED, ALGA=1 -> ADV_EN=1, 12 strobes, GOJ entered at the wrap, STOP=0.
- Optional counter: with TIMER_RUN_CTRL_MCT_CNT_EN and MCT_CNT_W=4, run 17 MCTs after GOJ exits -> MCT_CNT=1; MCT_CNT holds while STOPPED.
